// File: rtl/nes_cpu_pkg.sv
// Shared constants for the 6502 core control path: interrupt-kind codes,
// the BRK opcode forced during interrupt/reset sequences, and the default cycle width.
package nes_cpu_pkg;

  localparam int unsigned CYC_W_DEF   = 3;
  localparam int unsigned OPC_W_DEF   = 8;
  localparam logic [7:0]  BRK_OPC_DEF = 8'h00;

  typedef enum logic [1:0] {
    INT_NONE  = 2'd0,
    INT_IRQ   = 2'd1,
    INT_NMI   = 2'd2,
    INT_RESET = 2'd3
  } int_kind_t;

endpackage

// File: rtl/instr_int_arbiter.sv
// Interrupt source arbiter: NMI falling-edge detector, pending reset/NMI flags
// and the RESET > NMI > IRQ priority select that decides when BRK is forced.
module instr_int_arbiter
  import nes_cpu_pkg::*;
(
  input  logic      clk_ph1,
  input  logic      rst,
  input  logic      load,
  input  logic      nmi_n,
  input  logic      irq_n,
  input  logic      i_flag,
  output logic      force_brk,
  output int_kind_t kind
);

  logic r_nmi_prev;
  logic r_nmi_pend;
  logic r_rst_pend;
  logic w_nmi_edge;
  logic w_irq_take;

  assign w_nmi_edge = r_nmi_prev && !nmi_n;
  assign w_irq_take = !irq_n && !i_flag;

  // Edge detection ignores rdy; a fresh edge wins over the clear from a serving load.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_rst_pend <= 1'b1;
    end else begin
      r_nmi_prev <= nmi_n;
      if (w_nmi_edge)
        r_nmi_pend <= 1'b1;
      else if (load && !r_rst_pend)
        r_nmi_pend <= 1'b0;
      if (load)
        r_rst_pend <= 1'b0;
    end
  end

  always_comb begin
    force_brk = 1'b1;
    kind      = INT_NONE;
    if (r_rst_pend)
      kind = INT_RESET;
    else if (r_nmi_pend)
      kind = INT_NMI;
    else if (w_irq_take)
      kind = INT_IRQ;
    else
      force_brk = 1'b0;
  end

endmodule

// File: rtl/instr_sequencer.sv
// T-cycle counter and instruction register with RDY stall and BRK injection.
// Optional retired-opcode counter enabled by defining INSTR_SEQ_RETIRE_CNT_EN.
module instr_sequencer
  import nes_cpu_pkg::*;
#(
  parameter int unsigned      CYC_W   = CYC_W_DEF,
  parameter int unsigned      OPC_W   = OPC_W_DEF,
  parameter logic [OPC_W-1:0] BRK_OPC = OPC_W'(BRK_OPC_DEF)
) (
  input  logic             clk_ph1,
  input  logic             rst,
  input  logic             rdy,
  input  logic             I_cycle,
  input  logic             R_cycle,
  input  logic             S_cycle,
  input  logic [OPC_W-1:0] pd,
  input  logic             nmi_n,
  input  logic             irq_n,
  input  logic             i_flag,
  output logic [OPC_W-1:0] ir,
  output logic [CYC_W-1:0] cycle,
  output logic             sync,
  output logic [1:0]       int_kind,
  output logic [31:0]      instr_count
);

  logic [CYC_W-1:0] r_cycle;
  logic [OPC_W-1:0] r_ir;
  logic             r_sync;
  int_kind_t        r_kind;

  logic [CYC_W-1:0] w_next_cycle;
  logic             w_is_t1;
  logic             w_load;
  logic             w_force_brk;
  int_kind_t        w_kind;

  always_comb begin
    w_next_cycle = r_cycle;
    if (R_cycle)
      w_next_cycle = '0;
    else if (I_cycle)
      w_next_cycle = r_cycle + CYC_W'(1);
    else if (S_cycle)
      w_next_cycle = r_cycle + CYC_W'(2);
  end

  assign w_is_t1 = (w_next_cycle == CYC_W'(1));
  assign w_load  = rdy && w_is_t1;

  instr_int_arbiter u_arb (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .load      (w_load),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .i_flag    (i_flag),
    .force_brk (w_force_brk),
    .kind      (w_kind)
  );

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_cycle <= '1;
      r_ir    <= '0;
      r_sync  <= 1'b0;
      r_kind  <= INT_NONE;
    end else if (rdy) begin
      r_cycle <= w_next_cycle;
      r_sync  <= w_is_t1;
      if (w_load) begin
        r_ir   <= w_force_brk ? BRK_OPC : pd;
        r_kind <= w_kind;
      end
    end
  end

  assign ir       = r_ir;
  assign cycle    = r_cycle;
  assign sync     = r_sync;
  assign int_kind = r_kind;

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clk_ph1) begin
    if (!rst)
      r_instr_count <= '0;
    else if (w_load && !w_force_brk)
      r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer (default parameters, CYC_W=3).
module tb_instr_sequencer;

  logic        clk_ph1;
  logic        rst;
  logic        rdy;
  logic        I_cycle;
  logic        R_cycle;
  logic        S_cycle;
  logic [7:0]  pd;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic [7:0]  ir;
  logic [2:0]  cycle;
  logic        sync;
  logic [1:0]  int_kind;
  logic [31:0] instr_count;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] exp_retired;

  instr_sequencer #(.CYC_W(3), .OPC_W(8), .BRK_OPC(8'h00)) dut (
    .clk_ph1     (clk_ph1),
    .rst         (rst),
    .rdy         (rdy),
    .I_cycle     (I_cycle),
    .R_cycle     (R_cycle),
    .S_cycle     (S_cycle),
    .pd          (pd),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .i_flag      (i_flag),
    .ir          (ir),
    .cycle       (cycle),
    .sync        (sync),
    .int_kind    (int_kind),
    .instr_count (instr_count)
  );

  initial begin
    clk_ph1 = 1'b0;
    forever #5 clk_ph1 = ~clk_ph1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  // Two edges: clear to T0, then step into T1 (the load edge).
  task automatic fetch(input logic [7:0] op);
    pd = op;
    R_cycle = 1'b1; I_cycle = 1'b0; S_cycle = 1'b0;
    tick();
    R_cycle = 1'b0; I_cycle = 1'b1;
    tick();
    I_cycle = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] c, input logic [7:0] i,
                           input logic [1:0] k, input logic s);
    chk({tag, ".cycle"}, 32'(cycle), 32'(c));
    chk({tag, ".ir"}, 32'(ir), 32'(i));
    chk({tag, ".kind"}, 32'(int_kind), 32'(k));
    chk({tag, ".sync"}, 32'(sync), 32'(s));
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_retired = 0;
    rst = 1'b0; rdy = 1'b1; I_cycle = 1'b0; R_cycle = 1'b0; S_cycle = 1'b0;
    pd = 8'h00; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    tick(); tick();
    chk_state("reset", 3'd7, 8'h00, 2'd0, 1'b0);
    chk("reset.cnt", instr_count, 32'd0);

    // First load after reset release is always the RESET injection.
    rst = 1'b1; pd = 8'hA9; I_cycle = 1'b1;
    tick();
    chk_state("wrap7to0", 3'd0, 8'h00, 2'd0, 1'b0);
    tick();
    I_cycle = 1'b0;
    chk_state("rst_inj", 3'd1, 8'h00, 2'd3, 1'b1);
    I_cycle = 1'b1;
    tick();
    I_cycle = 1'b0;
    chk_state("t2", 3'd2, 8'h00, 2'd3, 1'b0);

    fetch(8'hA9); exp_retired++;
    chk_state("norm_a9", 3'd1, 8'hA9, 2'd0, 1'b1);

    // Skip arithmetic: 6+2 wraps to 0, I+S gives +1, R beats I.
    I_cycle = 1'b1;
    repeat (5) tick();
    I_cycle = 1'b0;
    chk("to6", 32'(cycle), 32'd6);
    S_cycle = 1'b1;
    tick();
    chk("skip6", 32'(cycle), 32'd0);
    pd = 8'h3C; I_cycle = 1'b1;
    tick(); exp_retired++;
    chk_state("i_and_s", 3'd1, 8'h3C, 2'd0, 1'b1);
    tick();
    chk("i_and_s2", 32'(cycle), 32'd2);
    R_cycle = 1'b1;
    tick();
    R_cycle = 1'b0; S_cycle = 1'b0;
    chk_state("r_and_i", 3'd0, 8'h3C, 2'd0, 1'b0);

    // Stall with I_cycle held; NMI edge during the stall is still captured.
    rdy = 1'b0; pd = 8'h55;
    tick();
    nmi_n = 1'b0;
    tick(); tick();
    chk_state("stall", 3'd0, 8'h3C, 2'd0, 1'b0);
    rdy = 1'b1;
    tick();
    I_cycle = 1'b0; nmi_n = 1'b1;
    chk_state("nmi_after_stall", 3'd1, 8'h00, 2'd2, 1'b1);

    irq_n = 1'b0; i_flag = 1'b1;
    fetch(8'h77); exp_retired++;
    chk_state("irq_masked", 3'd1, 8'h77, 2'd0, 1'b1);
    i_flag = 1'b0;
    fetch(8'h78);
    chk_state("irq_taken", 3'd1, 8'h00, 2'd1, 1'b1);

    // NMI pending alongside IRQ: NMI first, IRQ on the next T1.
    nmi_n = 1'b0;
    fetch(8'h99);
    chk_state("nmi_over_irq", 3'd1, 8'h00, 2'd2, 1'b1);
    fetch(8'h99);
    chk_state("irq_after_nmi", 3'd1, 8'h00, 2'd1, 1'b1);
    nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;

    // Second NMI edge on the very edge that serves the first.
    R_cycle = 1'b1;
    tick();
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    tick();
    R_cycle = 1'b0; I_cycle = 1'b1; nmi_n = 1'b0;
    tick();
    I_cycle = 1'b0;
    chk_state("nmi_serve", 3'd1, 8'h00, 2'd2, 1'b1);
    fetch(8'h11);
    chk_state("nmi_kept", 3'd1, 8'h00, 2'd2, 1'b1);
    fetch(8'h12); exp_retired++;
    chk_state("no_new_edge", 3'd1, 8'h12, 2'd0, 1'b1);

    fetch(8'hEA); exp_retired++;
    chk("ea", 32'(ir), 32'hEA);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    chk("retired", instr_count, exp_retired);
`else
    chk("retired_off", instr_count, 32'd0);
`endif

    // Mid-instruction reset, NMI held low through it: nmi_prev resets to 1.
    I_cycle = 1'b1;
    tick();
    I_cycle = 1'b0;
    chk("mid_t2", 32'(cycle), 32'd2);
    rst = 1'b0;
    tick();
    chk_state("mid_reset", 3'd7, 8'h00, 2'd0, 1'b0);
    chk("mid_reset.cnt", instr_count, 32'd0);
    rst = 1'b1; S_cycle = 1'b1; pd = 8'hA9;
    tick();
    S_cycle = 1'b0;
    chk_state("skip7_rst", 3'd1, 8'h00, 2'd3, 1'b1);
    fetch(8'hA9);
    chk_state("nmi_post_rst", 3'd1, 8'h00, 2'd2, 1'b1);
    nmi_n = 1'b1;
    fetch(8'hC8);
    chk_state("post_rst_norm", 3'd1, 8'hC8, 2'd0, 1'b1);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    chk("retired_post", instr_count, 32'd1);
`else
    chk("retired_post_off", instr_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
